mac_operand_feeder: RTL and testbench

Upstream operand stage for the 5-tap `mac` block. It accepts a stream of 8-bit samples over a valid/ready handshake and keeps a 5-deep sliding window, advancing by one sample per accepted input. It holds a writable bank of five 8-bit coefficients. Each window is presented on A1..A5 and the coefficients on c1..c5, qualified by `out_valid`, so the downstream `mac` sees stable operands for every window it consumes.

---
 rtl/mac_operand_feeder.sv | 96 +++++++++
 tb/tb_mac_operand_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_feeder.sv
// Operand stage for the 5-tap mac: slides a 5-sample window over the input
// stream and holds a coefficient bank, presenting both under out_valid.
module mac_operand_feeder #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    input  logic              coef_wr,
    input  logic [2:0]        coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic              coef_ready,
    output logic [DATA_W-1:0] A1,
    output logic [DATA_W-1:0] A2,
    output logic [DATA_W-1:0] A3,
    output logic [DATA_W-1:0] A4,
    output logic [DATA_W-1:0] A5,
    output logic [DATA_W-1:0] c1,
    output logic [DATA_W-1:0] c2,
    output logic [DATA_W-1:0] c3,
    output logic [DATA_W-1:0] c4,
    output logic [DATA_W-1:0] c5,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        fill_cnt
);

    localparam int TAPS = 5;

    // Index 0 is the newest sample (A1) / first coefficient (c1).
    logic [TAPS-1:0][DATA_W-1:0] win_q, win_d;
    logic [TAPS-1:0][DATA_W-1:0] coef_q, coef_d;
    logic [2:0]                  fill_q, fill_d;
    logic                        vld_q, vld_d;
    logic                        accept, consume;

    assign in_ready   = (!vld_q || out_ready) && !flush;
    assign coef_ready = !vld_q;
    assign accept     = in_valid && in_ready;
    assign consume    = vld_q && out_ready;

    always_comb begin
        win_d  = win_q;
        fill_d = fill_q;
        vld_d  = vld_q;
        coef_d = coef_q;
        if (flush) begin
            win_d  = '0;
            fill_d = 3'd0;
            vld_d  = 1'b0;
        end else begin
            if (accept) begin
                win_d  = {win_q[TAPS-2:0], in_data};
                fill_d = (fill_q == 3'd5) ? 3'd5 : fill_q + 3'd1;
            end
            if (accept && fill_q >= 3'd4)
                vld_d = 1'b1;
            else if (consume)
                vld_d = 1'b0;
        end
        // Coefficients survive flush; only out_valid gates writes.
        if (coef_wr && coef_ready && coef_addr < 3'd5)
            coef_d[coef_addr] = coef_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_q  <= '0;
            coef_q <= '0;
            fill_q <= 3'd0;
            vld_q  <= 1'b0;
        end else begin
            win_q  <= win_d;
            coef_q <= coef_d;
            fill_q <= fill_d;
            vld_q  <= vld_d;
        end
    end

    assign A1 = win_q[0];
    assign A2 = win_q[1];
    assign A3 = win_q[2];
    assign A4 = win_q[3];
    assign A5 = win_q[4];
    assign c1 = coef_q[0];
    assign c2 = coef_q[1];
    assign c3 = coef_q[2];
    assign c4 = coef_q[3];
    assign c5 = coef_q[4];
    assign out_valid = vld_q;
    assign fill_cnt  = fill_q;

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Directed bench for mac_operand_feeder: priming, stride, backpressure,
// coefficient gating, flush and async reset.
module tb_mac_operand_feeder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       flush;
    logic       coef_wr;
    logic [2:0] coef_addr;
    logic [7:0] coef_data;
    logic       coef_ready;
    logic [7:0] A1, A2, A3, A4, A5;
    logic [7:0] c1, c2, c3, c4, c5;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fill_cnt;

    int total = 0;
    int bad   = 0;

    mac_operand_feeder #(.DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data),
        .coef_ready(coef_ready),
        .A1(A1), .A2(A2), .A3(A3), .A4(A4), .A5(A5),
        .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5),
        .out_valid(out_valid), .out_ready(out_ready), .fill_cnt(fill_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_win(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                           input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
        chk({tag, ".A1"}, 32'(A1), 32'(e1));
        chk({tag, ".A2"}, 32'(A2), 32'(e2));
        chk({tag, ".A3"}, 32'(A3), 32'(e3));
        chk({tag, ".A4"}, 32'(A4), 32'(e4));
        chk({tag, ".A5"}, 32'(A5), 32'(e5));
    endtask

    task automatic chk_coef(input string tag, input logic [7:0] e1, input logic [7:0] e2,
                            input logic [7:0] e3, input logic [7:0] e4, input logic [7:0] e5);
        chk({tag, ".c1"}, 32'(c1), 32'(e1));
        chk({tag, ".c2"}, 32'(c2), 32'(e2));
        chk({tag, ".c3"}, 32'(c3), 32'(e3));
        chk({tag, ".c4"}, 32'(c4), 32'(e4));
        chk({tag, ".c5"}, 32'(c5), 32'(e5));
    endtask

    initial begin
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; flush = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0; out_ready = 1'b0;
        #12 rst_n = 1'b1;
        #1;
        chk("rst.out_valid", 32'(out_valid), 0);
        chk("rst.fill_cnt", 32'(fill_cnt), 0);
        chk("rst.in_ready", 32'(in_ready), 1);
        chk("rst.coef_ready", 32'(coef_ready), 1);
        chk_win("rst", 0, 0, 0, 0, 0);
        chk_coef("rst", 0, 0, 0, 0, 0);

        // Coefficients 1..5
        tick();
        for (int i = 0; i < 5; i++) begin
            coef_wr = 1'b1; coef_addr = 3'(i); coef_data = 8'(i + 1);
            tick();
        end
        coef_wr = 1'b0;
        chk_coef("cw", 1, 2, 3, 4, 5);

        // Prime with 10..50, out_ready low
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_data = 8'(10 * i);
            chk("prime.in_ready", 32'(in_ready), 1);
            tick();
            if (i == 4) begin
                chk("prime4.out_valid", 32'(out_valid), 0);
                chk("prime4.fill_cnt", 32'(fill_cnt), 4);
            end
        end
        in_valid = 1'b0;
        #1;
        chk("prime.out_valid", 32'(out_valid), 1);
        chk("prime.fill_cnt", 32'(fill_cnt), 5);
        chk("prime.in_ready", 32'(in_ready), 0);
        chk("prime.coef_ready", 32'(coef_ready), 0);
        chk_win("prime", 50, 40, 30, 20, 10);
        chk_coef("prime", 1, 2, 3, 4, 5);

        // Sliding stride with out_ready high
        out_ready = 1'b1; in_valid = 1'b1; in_data = 8'd60;
        #1 chk("slide.in_ready", 32'(in_ready), 1);
        tick();
        chk("slide1.out_valid", 32'(out_valid), 1);
        chk_win("slide1", 60, 50, 40, 30, 20);
        in_data = 8'd70;
        tick();
        chk("slide2.out_valid", 32'(out_valid), 1);
        chk_win("slide2", 70, 60, 50, 40, 30);
        in_valid = 1'b0;
        tick();
        chk("drain.out_valid", 32'(out_valid), 0);
        chk("drain.fill_cnt", 32'(fill_cnt), 5);
        chk_win("drain", 70, 60, 50, 40, 30);

        // Backpressure: present window {80..40}, then hold 99 off for 4 cycles
        out_ready = 1'b0; in_valid = 1'b1; in_data = 8'd80;
        tick();
        chk("bp.out_valid", 32'(out_valid), 1);
        chk_win("bp0", 80, 70, 60, 50, 40);
        in_data = 8'd99;
        for (int i = 0; i < 4; i++) begin
            chk("bp.in_ready", 32'(in_ready), 0);
            tick();
            chk("bp.A1", 32'(A1), 80);
            chk("bp.out_valid_hold", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1 chk("bp.release_in_ready", 32'(in_ready), 1);
        tick();
        chk_win("bp1", 99, 80, 70, 60, 50);
        chk("bp1.out_valid", 32'(out_valid), 1);
        in_valid = 1'b0;

        // Coefficient gating
        out_ready = 1'b0;
        coef_wr = 1'b1; coef_addr = 3'd2; coef_data = 8'd7;
        tick();
        chk("cg.dropped_c3", 32'(c3), 3);
        coef_wr = 1'b0; out_ready = 1'b1;
        tick();
        chk("cg.out_valid", 32'(out_valid), 0);
        coef_wr = 1'b1; coef_addr = 3'd2; coef_data = 8'd7;
        tick();
        chk("cg.c3", 32'(c3), 7);
        coef_addr = 3'd6; coef_data = 8'd9;
        tick();
        coef_wr = 1'b0;
        chk_coef("cg.addr6", 1, 2, 7, 4, 5);

        // Flush at fill_cnt=3 with a sample offered
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl0.fill_cnt", 32'(fill_cnt), 0);
        for (int i = 1; i <= 3; i++) begin
            in_valid = 1'b1; in_data = 8'(i);
            tick();
        end
        chk("fl.fill3", 32'(fill_cnt), 3);
        flush = 1'b1; in_data = 8'd4;
        #1 chk("fl.in_ready", 32'(in_ready), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl.fill_cnt", 32'(fill_cnt), 0);
        chk("fl.out_valid", 32'(out_valid), 0);
        chk_win("fl", 0, 0, 0, 0, 0);
        chk_coef("fl", 1, 2, 7, 4, 5);

        // Re-prime with 11..15
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1; in_data = 8'(10 + i);
            tick();
            if (i == 4) chk("rp4.out_valid", 32'(out_valid), 0);
        end
        in_valid = 1'b0;
        chk("rp.out_valid", 32'(out_valid), 1);
        chk_win("rp", 15, 14, 13, 12, 11);

        // Async reset during PRESENT
        #2 rst_n = 1'b0;
        #1;
        chk("ar.out_valid", 32'(out_valid), 0);
        chk("ar.fill_cnt", 32'(fill_cnt), 0);
        chk_win("ar", 0, 0, 0, 0, 0);
        chk_coef("ar", 0, 0, 0, 0, 0);
        chk("ar.in_ready", 32'(in_ready), 1);
        #3 rst_n = 1'b1;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
